fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
Round-robin arbiter and write-side controller sharing one async-FIFO write port among NREQ producers. Selects one producer per cycle, with optional bounded bursts. Drives FIFO RAM write enable, address and data. Owns the binary/Gray write pointer and computes full against the read-domain Gray pointer after a local synchronizer.

Parameters:
NREQ, 4, number of producers (2..8)
DATA_W, 8, data word width
ADDR_W, 7, FIFO address width; depth 2**ADDR_W; pointers are ADDR_W+1 bits
MAX_BURST, 4, max consecutive grants to one owner (1 = pure round-robin)
SYNC_STAGES, 2, flops in rgray_ptr synchronizer (>=2)

Ports:
clk  in  1  write-domain clock
reset  in  1  asynchronous, active-low reset
req  in  NREQ  per-producer write request, level
data_in  in  NREQ*DATA_W  producer i word at [i*DATA_W +: DATA_W]
rgray_ptr  in  ADDR_W+1  read pointer, Gray, from read domain (asynchronous)
grant  out  NREQ  one-hot; high = word from that producer written this cycle
grant_id  out  $clog2(NREQ)  index of granted producer, valid when wclken
wclken  out  1  RAM write enable (= |grant)
waddr  out  ADDR_W  RAM write address = wbin[ADDR_W-1:0]
wdata  out  DATA_W  selected producer word
wgray_ptr  out  ADDR_W+1  registered Gray write pointer, to read domain
wfull  out  1  registered full flag

Behaviour:
- Reset (reset=0, async): wbin=0, wgray_ptr=0, wfull=0, sync flops=0, state=ARB, prio=0, owner=0, burst_cnt=0. grant/wclken/grant_id forced 0 while reset is low.
- Write occurs in the same cycle as grant (combinational grant, zero latency). Pointer, prio and FSM update on that clock edge.
- No grant is ever issued while wfull=1. Non-granted producers must hold req and data_in.
- FSM ARB: if !wfull and |req, grant the first requester at or after prio (cyclic). Set burst_cnt=1, owner=idx.
  - If MAX_BURST>1: go to BURST.
  - Else: stay in ARB with prio=idx+1 mod NREQ.
- FSM BURST:
  - req[owner]=1, !wfull, burst_cnt<MAX_BURST: grant owner, burst_cnt++. If the new count equals MAX_BURST, go to ARB with prio=owner+1.
  - req[owner]=0: no grant this cycle (one-cycle bubble); go to ARB with prio=owner+1.
  - wfull=1 with req[owner]=1: stall in BURST, owner retained, no grant.
- Pointer: on wclken, wbin <= wbin+1, wrapping mod 2**(ADDR_W+1). wgray_ptr <= bin2gray(wbin_next).
- Synchronizer: rgray_ptr passes through SYNC_STAGES flops to give rq.
- Full: wfull <= (gray_next == {~rq[ADDR_W:ADDR_W-1], rq[ADDR_W-2:0]}), where gray_next is the post-write Gray value. wfull asserts the cycle after the filling write. It deasserts SYNC_STAGES+1 cycles after rgray_ptr advances.
- Reset mid-burst: all state returns to reset values immediately. The partial burst is abandoned and no further grant is issued.

Decomposition:
- Package fifo_pkg holds:
  - default ADDR_W
  - function bin2gray
  - typedef enum {ARB, BURST} arb_state_t
- Sub-module wptr_full_gen: synchronizer, binary/Gray pointer registers and full compare. Inputs clk, reset, inc, rgray_ptr; outputs waddr, wgray_ptr, wfull.
- Arbiter FSM and data mux stay in the top module.

Test Plan:
- Reset then req=4'b0001, rgray_ptr=0, 5 cycles -> grant[0] each cycle; waddr 0,1,2,3,4; wgray_ptr 0x01,0x03,0x02,0x06,0x07 after each edge.
- MAX_BURST=1, req=4'b1111 held -> grant sequence 0,1,2,3,0,...; grant_id matches; wdata equals the selected producer's word.
- MAX_BURST=4, req=4'b0011 held -> grant[0] x4 then grant[1] x4, repeating.
- Drop req[0] mid-burst -> one-cycle bubble, then grant[1].
- rgray_ptr=0, req=4'b0001 held -> 128 writes (waddr 0..127); wfull=1 from the next cycle; grant=0 and wgray_ptr=0xC0 held.
- From full, set rgray_ptr=0xC0 -> wfull=0 after SYNC_STAGES+1 cycles; 128 more writes wrap wbin 255->0 with wgray_ptr 0x80->0x00, then wfull=1 again.
- Assert reset mid-burst (burst_cnt=2) -> grant=0 immediately; after release wgray_ptr=0, wfull=0; first grant goes to producer 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
// Provides the default address width, the FSM state type and binary-to-Gray conversion.
package fifo_pkg;

  localparam int ADDR_W_DEFAULT = 7;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Callers cast narrower pointers up to 32 bits and keep the low bits.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/wptr_full_gen.sv
// Write pointer (binary and Gray), read-pointer synchronizer and registered full flag.
// The full flag compares the post-write Gray pointer against the synchronized read pointer.
module wptr_full_gen
  import fifo_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_inc,
  input  logic [ADDR_W:0]   i_rgray_ptr,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [ADDR_W:0]   o_wgray_ptr,
  output logic              o_wfull
);

  logic [ADDR_W:0]     r_sync [SYNC_STAGES];
  logic [ADDR_W:0]     r_wbin;
  logic [ADDR_W:0]     r_wgray;
  logic                r_wfull;

  logic [ADDR_W:0]     w_wbin_next;
  logic [ADDR_W:0]     w_wgray_next;
  logic [30-ADDR_W:0]  w_unused_gray;
  logic [ADDR_W:0]     w_rq;
  logic [ADDR_W:0]     w_full_tgt;

  assign w_wbin_next = r_wbin + {{ADDR_W{1'b0}}, i_inc};
  assign {w_unused_gray, w_wgray_next} = bin2gray(32'(w_wbin_next));

  // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
  assign w_rq       = r_sync[SYNC_STAGES-1];
  assign w_full_tgt = {~w_rq[ADDR_W:ADDR_W-1], w_rq[ADDR_W-2:0]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_wbin  <= '0;
      r_wgray <= '0;
      r_wfull <= 1'b0;
    end else begin
      r_sync[0] <= i_rgray_ptr;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_wbin  <= w_wbin_next;
      r_wgray <= w_wgray_next;
      r_wfull <= (w_wgray_next == w_full_tgt);
    end
  end

  assign o_waddr     = r_wbin[ADDR_W-1:0];
  assign o_wgray_ptr = r_wgray;
  assign o_wfull     = r_wfull;

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter with bounded bursts sharing one async-FIFO write port.
// Grant is combinational, so the selected word is written in the same cycle it is granted.
module fifo_write_arbiter
  import fifo_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = ADDR_W_DEFAULT,
  parameter int MAX_BURST   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NREQ-1:0]          i_req,
  input  logic [NREQ*DATA_W-1:0]   i_data_in,
  input  logic [ADDR_W:0]          i_rgray_ptr,
  output logic [NREQ-1:0]          o_grant,
  output logic [$clog2(NREQ)-1:0]  o_grant_id,
  output logic                     o_wclken,
  output logic [ADDR_W-1:0]        o_waddr,
  output logic [DATA_W-1:0]        o_wdata,
  output logic [ADDR_W:0]          o_wgray_ptr,
  output logic                     o_wfull
);

  localparam int IDW  = $clog2(NREQ);
  localparam int CNTW = $clog2(MAX_BURST + 1);

  arb_state_t      r_state;
  logic [IDW-1:0]  r_prio;
  logic [IDW-1:0]  r_owner;
  logic [CNTW-1:0] r_burst_cnt;

  logic            w_rr_found;
  logic [IDW-1:0]  w_rr_idx;
  logic            w_gnt_vld;
  logic [IDW-1:0]  w_gnt_idx;
  logic [NREQ-1:0] w_grant;
  logic [DATA_W-1:0] w_wdata;
  logic            w_wfull;

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] idx);
    if (int'(idx) == NREQ - 1) return '0;
    return idx + IDW'(1);
  endfunction

  // First requester at or after the priority pointer, searching cyclically.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      logic [IDW-1:0] j;
      j = IDW'((int'(r_prio) + k) % NREQ);
      if (!w_rr_found && i_req[j]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = j;
      end
    end
  end

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    case (r_state)
      ARB: begin
        if (!w_wfull && w_rr_found) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = w_rr_idx;
        end
      end
      BURST: begin
        if (i_req[r_owner] && !w_wfull && (r_burst_cnt < CNTW'(MAX_BURST))) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = r_owner;
        end
      end
      default: ;
    endcase
    if (!i_rst_n) w_gnt_vld = 1'b0;
  end

  always_comb begin
    w_grant = '0;
    w_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_idx == IDW'(i)) w_wdata = i_data_in[i*DATA_W +: DATA_W];
    end
    if (w_gnt_vld) w_grant[w_gnt_idx] = 1'b1;
  end

  // A dropped owner request or a completed burst hands priority to the next producer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ARB;
      r_prio      <= '0;
      r_owner     <= '0;
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        ARB: begin
          if (w_gnt_vld) begin
            r_owner     <= w_gnt_idx;
            r_burst_cnt <= CNTW'(1);
            if (MAX_BURST > 1) r_state <= BURST;
            else               r_prio  <= next_idx(w_gnt_idx);
          end
        end
        BURST: begin
          if (w_gnt_vld) begin
            r_burst_cnt <= r_burst_cnt + CNTW'(1);
            if (r_burst_cnt + CNTW'(1) == CNTW'(MAX_BURST)) begin
              r_state <= ARB;
              r_prio  <= next_idx(r_owner);
            end
          end else if (!i_req[r_owner]) begin
            r_state <= ARB;
            r_prio  <= next_idx(r_owner);
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

  wptr_full_gen #(
    .ADDR_W      (ADDR_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_wptr_full_gen (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_inc       (w_gnt_vld),
    .i_rgray_ptr (i_rgray_ptr),
    .o_waddr     (o_waddr),
    .o_wgray_ptr (o_wgray_ptr),
    .o_wfull     (w_wfull)
  );

  assign o_grant    = w_grant;
  assign o_grant_id = w_gnt_vld ? w_gnt_idx : '0;
  assign o_wclken   = w_gnt_vld;
  assign o_wdata    = w_wdata;
  assign o_wfull    = w_wfull;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench: a burst-capable instance (MAX_BURST=4) and a pure round-robin one (MAX_BURST=1).
module tb_fifo_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  a_req, b_req;
  logic [31:0] data;
  logic [7:0]  a_rgray, b_rgray;

  logic [3:0]  a_grant, b_grant;
  logic [1:0]  a_id, b_id;
  logic        a_wclken, b_wclken;
  logic [6:0]  a_waddr, b_waddr;
  logic [7:0]  a_wdata, b_wdata;
  logic [7:0]  a_wgray, b_wgray;
  logic        a_wfull, b_wfull;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       rst;
    logic       selb;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
    logic [6:0] waddr;
    logic [7:0] gray;
    logic [7:0] wdata;
  } vec_t;

  vec_t vq[$];

  fifo_write_arbiter #(.NREQ(4), .DATA_W(8), .ADDR_W(7), .MAX_BURST(4), .SYNC_STAGES(2)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(a_req), .i_data_in(data), .i_rgray_ptr(a_rgray),
    .o_grant(a_grant), .o_grant_id(a_id), .o_wclken(a_wclken), .o_waddr(a_waddr),
    .o_wdata(a_wdata), .o_wgray_ptr(a_wgray), .o_wfull(a_wfull)
  );

  fifo_write_arbiter #(.NREQ(4), .DATA_W(8), .ADDR_W(7), .MAX_BURST(1), .SYNC_STAGES(2)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(b_req), .i_data_in(data), .i_rgray_ptr(b_rgray),
    .o_grant(b_grant), .o_grant_id(b_id), .o_wclken(b_wclken), .o_waddr(b_waddr),
    .o_wdata(b_wdata), .o_wgray_ptr(b_wgray), .o_wfull(b_wfull)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void add(input logic rst, input logic selb, input logic [3:0] req,
                              input logic [3:0] gnt, input logic [1:0] id, input logic [6:0] waddr,
                              input logic [7:0] gray, input logic [7:0] wdata);
    vq.push_back('{rst, selb, req, gnt, id, waddr, gray, wdata});
  endfunction

  // Called at a falling edge; leaves reset released at the next falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_grant_a", 32'(a_grant), 32'h0);
    chk("rst_wclken_a", 32'(a_wclken), 32'h0);
    chk("rst_grant_b", 32'(b_grant), 32'h0);
    chk("rst_wgray_a", 32'(a_wgray), 32'h0);
    chk("rst_wfull_a", 32'(a_wfull), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    a_req   = '0;
    b_req   = '0;
    data    = 32'hD3C2B1A0;
    a_rgray = '0;
    b_rgray = '0;

    // Single producer, continuous writes
    add(1, 0, 4'b0001, 4'b0001, 2'd0, 7'd0, 8'h01, 8'hA0);
    add(0, 0, 4'b0001, 4'b0001, 2'd0, 7'd1, 8'h03, 8'hA0);
    add(0, 0, 4'b0001, 4'b0001, 2'd0, 7'd2, 8'h02, 8'hA0);
    add(0, 0, 4'b0001, 4'b0001, 2'd0, 7'd3, 8'h06, 8'hA0);
    add(0, 0, 4'b0001, 4'b0001, 2'd0, 7'd4, 8'h07, 8'hA0);
    // Bursts of four alternating between producers 0 and 1
    add(1, 0, 4'b0011, 4'b0001, 2'd0, 7'd0,  8'h01, 8'hA0);
    add(0, 0, 4'b0011, 4'b0001, 2'd0, 7'd1,  8'h03, 8'hA0);
    add(0, 0, 4'b0011, 4'b0001, 2'd0, 7'd2,  8'h02, 8'hA0);
    add(0, 0, 4'b0011, 4'b0001, 2'd0, 7'd3,  8'h06, 8'hA0);
    add(0, 0, 4'b0011, 4'b0010, 2'd1, 7'd4,  8'h07, 8'hB1);
    add(0, 0, 4'b0011, 4'b0010, 2'd1, 7'd5,  8'h05, 8'hB1);
    add(0, 0, 4'b0011, 4'b0010, 2'd1, 7'd6,  8'h04, 8'hB1);
    add(0, 0, 4'b0011, 4'b0010, 2'd1, 7'd7,  8'h0C, 8'hB1);
    add(0, 0, 4'b0011, 4'b0001, 2'd0, 7'd8,  8'h0D, 8'hA0);
    add(0, 0, 4'b0011, 4'b0001, 2'd0, 7'd9,  8'h0F, 8'hA0);
    add(0, 0, 4'b0011, 4'b0001, 2'd0, 7'd10, 8'h0E, 8'hA0);
    add(0, 0, 4'b0011, 4'b0001, 2'd0, 7'd11, 8'h0A, 8'hA0);
    // Owner drops its request mid-burst: bubble, then producer 1
    add(1, 0, 4'b0011, 4'b0001, 2'd0, 7'd0, 8'h01, 8'hA0);
    add(0, 0, 4'b0011, 4'b0001, 2'd0, 7'd1, 8'h03, 8'hA0);
    add(0, 0, 4'b0010, 4'b0000, 2'd0, 7'd2, 8'h03, 8'h00);
    add(0, 0, 4'b0010, 4'b0010, 2'd1, 7'd2, 8'h02, 8'hB1);
    // Pure round-robin instance, all requesting
    add(1, 1, 4'b1111, 4'b0001, 2'd0, 7'd0, 8'h01, 8'hA0);
    add(0, 1, 4'b1111, 4'b0010, 2'd1, 7'd1, 8'h03, 8'hB1);
    add(0, 1, 4'b1111, 4'b0100, 2'd2, 7'd2, 8'h02, 8'hC2);
    add(0, 1, 4'b1111, 4'b1000, 2'd3, 7'd3, 8'h06, 8'hD3);
    add(0, 1, 4'b1111, 4'b0001, 2'd0, 7'd4, 8'h07, 8'hA0);
    add(0, 1, 4'b1111, 4'b0010, 2'd1, 7'd5, 8'h05, 8'hB1);
    add(0, 1, 4'b1111, 4'b0100, 2'd2, 7'd6, 8'h04, 8'hC2);
    add(0, 1, 4'b1111, 4'b1000, 2'd3, 7'd7, 8'h0C, 8'hD3);

    @(negedge clk);
    do_reset();

    foreach (vq[n]) begin
      @(negedge clk);
      if (vq[n].rst) do_reset();
      a_req = vq[n].selb ? 4'b0000 : vq[n].req;
      b_req = vq[n].selb ? vq[n].req : 4'b0000;
      #1;
      chk($sformatf("v%0d_grant", n),  32'(vq[n].selb ? b_grant : a_grant), 32'(vq[n].gnt));
      chk($sformatf("v%0d_wclken", n), 32'(vq[n].selb ? b_wclken : a_wclken), 32'(|vq[n].gnt));
      chk($sformatf("v%0d_waddr", n),  32'(vq[n].selb ? b_waddr : a_waddr), 32'(vq[n].waddr));
      if (|vq[n].gnt) begin
        chk($sformatf("v%0d_id", n),    32'(vq[n].selb ? b_id : a_id), 32'(vq[n].id));
        chk($sformatf("v%0d_wdata", n), 32'(vq[n].selb ? b_wdata : a_wdata), 32'(vq[n].wdata));
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wgray", n), 32'(vq[n].selb ? b_wgray : a_wgray), 32'(vq[n].gray));
    end

    // Fill the FIFO from empty, then hold at full
    @(negedge clk);
    b_req = '0;
    a_rgray = 8'h00;
    do_reset();
    a_req = 4'b0001;
    for (int i = 0; i < 128; i++) begin
      #1;
      chk($sformatf("fill_grant_%0d", i), 32'(a_grant), 32'h1);
      chk($sformatf("fill_waddr_%0d", i), 32'(a_waddr), 32'(i));
      @(negedge clk);
    end
    #1;
    chk("full_set", 32'(a_wfull), 32'h1);
    chk("full_wgray", 32'(a_wgray), 32'hC0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("full_hold_grant_%0d", i), 32'(a_grant), 32'h0);
      chk($sformatf("full_hold_wgray_%0d", i), 32'(a_wgray), 32'hC0);
    end

    // Reader catches up: full clears after the synchronizer plus the flag register
    @(negedge clk);
    a_rgray = 8'hC0;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("drain_wfull_e%0d", e), 32'(a_wfull), (e < 3) ? 32'h1 : 32'h0);
    end
    @(negedge clk);
    for (int i = 0; i < 128; i++) begin
      #1;
      chk($sformatf("wrap_grant_%0d", i), 32'(a_grant), 32'h1);
      chk($sformatf("wrap_waddr_%0d", i), 32'(a_waddr), 32'(i));
      @(posedge clk);
      #1;
      if (i == 126) chk("wrap_wgray_255", 32'(a_wgray), 32'h80);
      if (i == 127) chk("wrap_wgray_0", 32'(a_wgray), 32'h00);
      @(negedge clk);
    end
    #1;
    chk("refull_set", 32'(a_wfull), 32'h1);
    chk("refull_grant", 32'(a_grant), 32'h0);

    // Reset in the middle of a burst
    a_rgray = 8'h00;
    do_reset();
    a_req = 4'b0011;
    #1;
    chk("mid_grant_1", 32'(a_grant), 32'h1);
    @(negedge clk);
    #1;
    chk("mid_grant_2", 32'(a_grant), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(a_grant), 32'h0);
    chk("mid_rst_wclken", 32'(a_wclken), 32'h0);
    chk("mid_rst_wgray", 32'(a_wgray), 32'h0);
    chk("mid_rst_wfull", 32'(a_wfull), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_grant", 32'(a_grant), 32'h1);
    chk("post_rst_id", 32'(a_id), 32'h0);
    chk("post_rst_waddr", 32'(a_waddr), 32'h0);
    chk("post_rst_wgray", 32'(a_wgray), 32'h0);
    @(negedge clk);
    a_req = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
